fpga_mem_loader: RTL and testbench

Host-side loader for the FPGA build that streams 32-bit words from the AXI fabric into the wider Caliptra-side memories (IMEM/ROM, mailbox SRAM, future targets) through their secondary port. It generalises the fixed 32-bit BRAM port-B path to parametrised memory width, address depth and target count. It adds width packing, a running checksum, address-range checking and a one-way ROM write lock. It sits in the AXI clock domain between the host register/stream logic and port B of each target memory.

---
 rtl/fpga_loader_pkg.sv | 19 +
 rtl/fpga_loader_pack.sv | 46 ++++
 rtl/fpga_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_fpga_mem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_loader_pkg.sv
// Shared types and helpers for the host-to-memory loader.
// State encoding, ROM target index and host-word to memory-word count conversion.
package fpga_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_WRITE,
    S_DONE
  } loader_state_e;

  localparam int unsigned ROM_TGT = 0;

  // Memory words needed for cnt host words at r host words per memory word.
  function automatic logic [31:0] mem_words(input logic [31:0] cnt, input int unsigned r);
    return (cnt + 32'(r) - 32'd1) / 32'(r);
  endfunction

endpackage

// File: rtl/fpga_loader_pack.sv
// R-lane little-endian pack buffer; word_dat already includes the word being pushed.
// Latency 0 to word_dat; no backpressure of its own, clr empties and zero-pads.
module fpga_loader_pack #(
  parameter  int HOST_DW = 32,
  parameter  int R       = 2,
  localparam int MEM_DW  = HOST_DW * R,
  localparam int LW      = (R > 1) ? $clog2(R) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push_vld,
  input  logic [HOST_DW-1:0] push_dat,
  output logic [MEM_DW-1:0]  word_dat,
  output logic              lane_last
);

  logic [MEM_DW-1:0] pack_q;
  logic [LW-1:0]     lane_q;

  always_comb begin
    word_dat = pack_q;
    for (int i = 0; i < R; i++) begin
      if (push_vld && lane_q == LW'(i)) begin
        word_dat[i*HOST_DW +: HOST_DW] = push_dat;
      end
    end
  end

  assign lane_last = (lane_q == LW'(R - 1));

  // Clearing on flush leaves unused upper lanes at zero for a short final word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= '0;
      lane_q <= '0;
    end else if (clr) begin
      pack_q <= '0;
      lane_q <= '0;
    end else if (push_vld) begin
      pack_q <= word_dat;
      lane_q <= lane_q + LW'(1);
    end
  end

endmodule

// File: rtl/fpga_mem_loader.sv
// Streams host words into a selected wide memory via port B, with checksum, range check and ROM lock.
// R accept cycles plus one write cycle per memory word; in_ready drops while writing or idle.
module fpga_mem_loader
  import fpga_loader_pkg::*;
#(
  parameter  int HOST_DW = 32,
  parameter  int MEM_DW  = 64,
  parameter  int MEM_AW  = 13,
  parameter  int NUM_TGT = 2,
  localparam int R       = MEM_DW / HOST_DW,
  localparam int TW      = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1,
  localparam int CW      = MEM_AW + $clog2(R) + 1
) (
  input  logic                axi_bram_clk,
  input  logic                axi_bram_rst,
  input  logic                start,
  input  logic [TW-1:0]       tgt_sel,
  input  logic [MEM_AW-1:0]   base_addr,
  input  logic [CW-1:0]       word_cnt,
  input  logic                lock_req,
  input  logic                in_valid,
  input  logic [HOST_DW-1:0]  in_data,
  output logic                in_ready,
  output logic [NUM_TGT-1:0]  mem_en,
  output logic [MEM_DW/8-1:0] mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                locked,
  output logic [31:0]         csum
);

  loader_state_e state_q, state_d;

  logic [TW-1:0]     tgt_q;
  logic [MEM_AW-1:0] addr_q;
  logic [CW-1:0]     rem_q;

  logic              acc;
  logic              go;
  logic              to_write;
  logic              rej;
  logic              bad_tgt;
  logic              bad_range;
  logic [31:0]       need_words;
  logic [32:0]       end_addr;
  logic [MEM_DW-1:0] pack_word;
  logic              lane_last;

  assign acc = in_valid && in_ready;

  // Range sum is kept one bit wider than the address so a top-of-memory overrun is visible.
  always_comb begin
    need_words = mem_words(32'(word_cnt), R);
    end_addr   = {1'b0, 32'(base_addr)} + {1'b0, need_words};
    bad_range  = end_addr > (33'd1 << MEM_AW);
    bad_tgt    = (32'(tgt_sel) >= 32'(NUM_TGT)) || ((32'(tgt_sel) == ROM_TGT) && locked);
    rej        = bad_tgt || bad_range;
  end

  always_ff @(posedge axi_bram_clk or posedge axi_bram_rst) begin
    if (axi_bram_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    go       = 1'b0;
    to_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          go      = 1'b1;
          state_d = (rej || word_cnt == '0) ? S_DONE : S_PACK;
        end
      end
      S_PACK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc && (lane_last || rem_q == CW'(1))) begin
          to_write = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        busy    = 1'b1;
        state_d = (rem_q != '0) ? S_PACK : S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes are registered on entry to WRITE, so they are high only during that cycle.
  always_ff @(posedge axi_bram_clk or posedge axi_bram_rst) begin
    if (axi_bram_rst) begin
      tgt_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      mem_en    <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      locked    <= 1'b0;
      csum      <= '0;
    end else begin
      mem_en <= '0;
      mem_we <= '0;
      if (lock_req) begin
        locked <= 1'b1;
      end
      if (go) begin
        err    <= rej;
        csum   <= '0;
        tgt_q  <= tgt_sel;
        addr_q <= base_addr;
        rem_q  <= word_cnt;
      end
      if (acc) begin
        csum  <= csum + 32'(in_data);
        rem_q <= rem_q - CW'(1);
      end
      if (to_write) begin
        mem_en    <= NUM_TGT'(1) << tgt_q;
        mem_we    <= '1;
        mem_addr  <= addr_q;
        mem_wdata <= pack_word;
      end
      if (state_q == S_WRITE) begin
        addr_q <= addr_q + MEM_AW'(1);
      end
    end
  end

  fpga_loader_pack #(
    .HOST_DW (HOST_DW),
    .R       (R)
  ) u_pack (
    .clk       (axi_bram_clk),
    .rst       (axi_bram_rst),
    .clr       (go || to_write),
    .push_vld  (acc),
    .push_dat  (in_data),
    .word_dat  (pack_word),
    .lane_last (lane_last)
  );

endmodule

// File: tb/tb_fpga_mem_loader.sv
// Directed and randomized loads checked against a queue-based model of the loader's rules.
module tb_fpga_mem_loader;

  localparam int HOST_DW = 32;
  localparam int MEM_DW  = 64;
  localparam int MEM_AW  = 13;
  localparam int NUM_TGT = 2;
  localparam int R       = MEM_DW / HOST_DW;
  localparam int CW      = MEM_AW + 1 + 1;

  logic               axi_bram_clk;
  logic               axi_bram_rst;
  logic               start;
  logic [0:0]         tgt_sel;
  logic [MEM_AW-1:0]  base_addr;
  logic [CW-1:0]      word_cnt;
  logic               lock_req;
  logic               in_valid;
  logic [HOST_DW-1:0] in_data;
  logic               in_ready;
  logic [NUM_TGT-1:0] mem_en;
  logic [7:0]         mem_we;
  logic [MEM_AW-1:0]  mem_addr;
  logic [MEM_DW-1:0]  mem_wdata;
  logic               busy;
  logic               done;
  logic               err;
  logic               locked;
  logic [31:0]        csum;

  fpga_mem_loader #(
    .HOST_DW (HOST_DW),
    .MEM_DW  (MEM_DW),
    .MEM_AW  (MEM_AW),
    .NUM_TGT (NUM_TGT)
  ) dut (
    .axi_bram_clk (axi_bram_clk),
    .axi_bram_rst (axi_bram_rst),
    .start        (start),
    .tgt_sel      (tgt_sel),
    .base_addr    (base_addr),
    .word_cnt     (word_cnt),
    .lock_req     (lock_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .locked       (locked),
    .csum         (csum)
  );

  initial axi_bram_clk = 1'b0;
  always #5 axi_bram_clk = ~axi_bram_clk;

  typedef struct {
    logic [NUM_TGT-1:0] en;
    logic [7:0]         we;
    logic [MEM_AW-1:0]  addr;
    logic [MEM_DW-1:0]  data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] stim[$];
  int          tests = 0;
  int          fails = 0;
  bit          locked_m = 1'b0;

  // Every cycle with an enable raised is one memory write.
  always @(negedge axi_bram_clk) begin
    if (mem_en != '0) begin
      wr_t w;
      w.en   = mem_en;
      w.we   = mem_we;
      w.addr = mem_addr;
      w.data = mem_wdata;
      wq.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".csum"}, csum, 0);
  endtask

  // Runs one load of stim[0..cnt-1]; gap is the percent chance of an idle host cycle.
  task automatic run_load(input int tgt, input int base, input int cnt, input int gap,
                          input bit lock_mid, input bit start_mid, input string tag);
    int          nw, idx, lat, exp_lat;
    bit          rej, pend, got;
    logic [63:0] d;
    logic [31:0] esum;
    wr_t         ew[$];
    wr_t         e;

    nw   = (cnt + R - 1) / R;
    rej  = (tgt == 0 && locked_m) || (base + nw > (1 << MEM_AW));
    esum = 0;
    if (!rej) begin
      for (int k = 0; k < cnt; k++) esum += stim[k];
      for (int i = 0; i < nw; i++) begin
        d = '0;
        for (int j = 0; j < R; j++) begin
          if (i * R + j < cnt) d = d | (64'(stim[i*R+j]) << (HOST_DW * j));
        end
        e.en   = 2'(1 << tgt);
        e.we   = 8'hFF;
        e.addr = 13'(base + i);
        e.data = d;
        ew.push_back(e);
      end
    end
    exp_lat = (rej || cnt == 0) ? 1 : cnt + nw + 1;

    wq.delete();
    @(negedge axi_bram_clk);
    start     = 1'b1;
    tgt_sel   = tgt[0:0];
    base_addr = base[MEM_AW-1:0];
    word_cnt  = cnt[CW-1:0];
    @(negedge axi_bram_clk);
    start = 1'b0;
    lat   = 1;
    idx   = 0;
    pend  = 1'b0;
    got   = 1'b0;
    if (!rej && cnt > 0) chk({tag, ".busy_after_start"}, busy, 1);

    for (int c = 0; c < 400; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = start_mid && c == 2;
      if (start) begin
        tgt_sel   = ~tgt_sel;
        base_addr = base_addr + 13'd1;
        word_cnt  = 15'd1;
      end
      lock_req = lock_mid && c == 1;
      if (lock_req) locked_m = 1'b1;
      if (!pend && idx < cnt && $urandom_range(99) >= gap) pend = 1'b1;
      in_valid = pend;
      in_data  = pend ? stim[idx] : $urandom;
      if (pend && in_ready) begin
        idx++;
        pend = 1'b0;
      end
      @(negedge axi_bram_clk);
      lat++;
    end
    start    = 1'b0;
    lock_req = 1'b0;
    in_valid = 1'b0;

    chk({tag, ".done_seen"}, got, 1);
    if (gap == 0 || rej || cnt == 0) chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, err, rej);
    chk({tag, ".csum"}, csum, esum);
    chk({tag, ".consumed"}, idx, rej ? 0 : cnt);
    chk({tag, ".nwrites"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      chk({tag, ".en"}, wq[i].en, ew[i].en);
      chk({tag, ".we"}, wq[i].we, ew[i].we);
      chk({tag, ".addr"}, wq[i].addr, ew[i].addr);
      chk({tag, ".data"}, wq[i].data, ew[i].data);
    end
    @(negedge axi_bram_clk);
    chk({tag, ".done_one_cycle"}, done, 0);
    chk({tag, ".busy_after_done"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, base, cnt;

    axi_bram_rst = 1'b1;
    start        = 1'b0;
    tgt_sel      = '0;
    base_addr    = '0;
    word_cnt     = '0;
    lock_req     = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    #1;
    chk_reset("reset");
    repeat (3) @(negedge axi_bram_clk);
    axi_bram_rst = 1'b0;

    stim = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_load(1, 'h10, 4, 0, 1'b0, 1'b0, "basic");

    stim = '{32'hA, 32'hB, 32'hC};
    run_load(1, 0, 3, 40, 1'b0, 1'b0, "odd");

    stim = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    run_load(0, 'h100, 5, 0, 1'b1, 1'b0, "rom_lock_mid");
    chk("locked_set", locked, 1);

    run_load(0, 0, 2, 0, 1'b0, 1'b0, "rom_locked_reject");
    stim = '{32'hDEAD, 32'hBEEF};
    run_load(1, 0, 2, 0, 1'b0, 1'b0, "after_reject");

    stim = '{32'h7, 32'h8, 32'h9};
    run_load(1, 'h1FFF, 3, 0, 1'b0, 1'b0, "range_reject");
    run_load(1, 'h1FFF, 2, 0, 1'b0, 1'b0, "range_top");
    run_load(1, 'h1FFF, 3, 0, 1'b0, 1'b0, "range_reject2");
    run_load(1, 'h40, 0, 0, 1'b0, 1'b0, "empty");

    stim = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 32'hCAFE0005, 32'hCAFE0006};
    run_load(1, 'h200, 6, 30, 1'b0, 1'b1, "start_while_busy");

    for (int t = 0; t < 25; t++) begin
      tgt  = $urandom_range(1, 0);
      cnt  = $urandom_range(9, 0);
      base = ($urandom_range(3, 0) == 0) ? (1 << MEM_AW) - $urandom_range(6, 1)
                                          : $urandom_range((1 << MEM_AW) - 1, 0);
      stim.delete();
      for (int k = 0; k < cnt; k++) stim.push_back($urandom);
      run_load(tgt, base, cnt, $urandom_range(50, 0), 1'b0, 1'b0, "random");
    end

    // Abort a two-word load after one word has been accepted.
    wq.delete();
    @(negedge axi_bram_clk);
    start     = 1'b1;
    tgt_sel   = 1'b1;
    base_addr = 13'h5;
    word_cnt  = 15'd2;
    @(negedge axi_bram_clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    @(negedge axi_bram_clk);
    in_valid     = 1'b0;
    axi_bram_rst = 1'b1;
    #1;
    chk_reset("abort");
    repeat (3) @(negedge axi_bram_clk);
    axi_bram_rst = 1'b0;
    locked_m     = 1'b0;
    repeat (2) @(negedge axi_bram_clk);
    chk("abort.nwrites", wq.size(), 0);

    stim = '{32'h5, 32'h6, 32'h7};
    run_load(0, 'h30, 3, 20, 1'b0, 1'b0, "rom_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
